// File: rtl/l1d_axi_mem_responder.sv
// AXI responder terminating the L1D master port: queued, latency-programmable INCR reads
// and single-outstanding INCR writes against a word-addressed internal array.
module l1d_axi_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 3,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned RD_LATENCY = 4,
  parameter int unsigned RQ_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  input  logic [ADDR_WIDTH-1:0] axi_araddr,
  input  logic [ID_WIDTH-1:0]   axi_arid,
  input  logic [2:0]            axi_arsize,
  input  logic [7:0]            axi_arlen,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic [DATA_WIDTH-1:0] axi_rdata,
  output logic [ID_WIDTH-1:0]   axi_rid,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rlast,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [ADDR_WIDTH-1:0] axi_awaddr,
  input  logic [ID_WIDTH-1:0]   axi_awid,
  input  logic [1:0]            axi_awburst,
  input  logic [2:0]            axi_awsize,
  input  logic [7:0]            axi_awlen,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  input  logic [DATA_WIDTH-1:0] axi_wdata,
  input  logic                  axi_wlast,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  output logic [ID_WIDTH-1:0]   axi_bid,
  output logic [1:0]            axi_bresp
);

  localparam int unsigned BYTES   = DATA_WIDTH / 8;
  localparam int unsigned OFF_W   = $clog2(BYTES);
  localparam int unsigned IDX_W   = $clog2(MEM_WORDS);
  localparam int unsigned QP_W    = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  localparam int unsigned QC_W    = $clog2(RQ_DEPTH + 1);
  localparam logic [2:0]  SIZE_OK = 3'(OFF_W);
  localparam logic [15:0] LAT     = 16'(RD_LATENCY);
  localparam logic [1:0]  OKAY    = 2'b00;
  localparam logic [1:0]  SLVERR  = 2'b10;

  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_BURST = 1'b1;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return |(a >> (OFF_W + IDX_W));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [QP_W-1:0] ptr_inc(input logic [QP_W-1:0] p);
    return (p == QP_W'(RQ_DEPTH - 1)) ? '0 : p + QP_W'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [15:0] cyc_cnt;

  // read-request queue
  logic [IDX_W-1:0]    q_idx [RQ_DEPTH];
  logic [ID_WIDTH-1:0] q_id  [RQ_DEPTH];
  logic [7:0]          q_len [RQ_DEPTH];
  logic                q_err [RQ_DEPTH];
  logic [15:0]         q_rdy [RQ_DEPTH];
  logic [QP_W-1:0]     q_wp, q_rp;
  logic [QC_W-1:0]     q_cnt;
  logic                q_full, q_empty;
  logic [15:0]         head_slack;
  logic                head_elig;
  logic                q_pop, ar_hs;

  // read engine
  logic [0:0]            r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [7:0]            r_cnt, r_len;
  logic                  r_err;
  logic                  r_hs, r_done;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  // write engine
  logic [1:0]       w_state;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_cnt, w_len;
  logic             w_err;
  logic             aw_hs, w_hs, w_last_beat, w_wlast_bad;

  always_ff @(posedge clk) begin
    if (rst) cyc_cnt <= '0;
    else     cyc_cnt <= cyc_cnt + 16'd1;
  end

  assign q_full  = (q_cnt == QC_W'(RQ_DEPTH));
  assign q_empty = (q_cnt == '0);

  // Launching at the edge where cyc_cnt+1 reaches ready_cyc puts the first beat on the bus
  // in the cycle whose count equals ready_cyc; the sign bit gives the mod-2^16 ordering.
  assign head_slack = cyc_cnt + 16'd1 - q_rdy[q_rp];
  assign head_elig  = !q_empty && !head_slack[15];

  assign axi_rvalid = (r_state == R_BURST);
  assign r_hs       = axi_rvalid && axi_rready;
  assign r_done     = r_hs && axi_rlast;
  assign q_pop      = head_elig && ((r_state == R_IDLE) || r_done);

  // A pop frees a slot in the same cycle, so a full queue can still take an AR then.
  assign axi_arready = !q_full || q_pop;
  assign ar_hs       = axi_arvalid && axi_arready;

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      q_idx[q_wp] <= word_idx(axi_araddr);
      q_id[q_wp]  <= axi_arid;
      q_len[q_wp] <= axi_arlen;
      q_err[q_wp] <= out_of_range(axi_araddr) || (axi_arsize != SIZE_OK);
      q_rdy[q_wp] <= cyc_cnt + LAT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_wp  <= '0;
      q_rp  <= '0;
      q_cnt <= '0;
    end else begin
      if (ar_hs) q_wp <= ptr_inc(q_wp);
      if (q_pop) q_rp <= ptr_inc(q_rp);
      case ({ar_hs, q_pop})
        2'b10:   q_cnt <= q_cnt + QC_W'(1);
        2'b01:   q_cnt <= q_cnt - QC_W'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // Array read happens at the launching edge, so a same-cycle write to that word is not seen.
  assign rd_idx  = q_pop ? q_idx[q_rp] : r_idx;
  assign rd_word = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= R_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_err     <= 1'b0;
      axi_rdata <= '0;
      axi_rid   <= '0;
      axi_rresp <= OKAY;
      axi_rlast <= 1'b0;
    end else if (q_pop) begin
      r_state   <= R_BURST;
      r_idx     <= q_idx[q_rp] + IDX_W'(1);
      r_cnt     <= '0;
      r_len     <= q_len[q_rp];
      r_err     <= q_err[q_rp];
      axi_rdata <= q_err[q_rp] ? '0 : rd_word;
      axi_rid   <= q_id[q_rp];
      axi_rresp <= q_err[q_rp] ? SLVERR : OKAY;
      axi_rlast <= (q_len[q_rp] == 8'd0);
    end else if (r_done) begin
      r_state <= R_IDLE;
    end else if (r_hs) begin
      r_idx     <= r_idx + IDX_W'(1);
      r_cnt     <= r_cnt + 8'd1;
      axi_rdata <= r_err ? '0 : rd_word;
      axi_rlast <= ((r_cnt + 8'd1) == r_len);
    end
  end

  assign axi_awready = (w_state == W_IDLE);
  assign axi_wready  = (w_state == W_DATA);
  assign axi_bvalid  = (w_state == W_RESP);
  assign aw_hs       = axi_awvalid && axi_awready;
  assign w_hs        = axi_wvalid && axi_wready;
  assign w_last_beat = (w_cnt == w_len);
  assign w_wlast_bad = (axi_wlast != w_last_beat);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      w_idx     <= '0;
      w_cnt     <= '0;
      w_len     <= '0;
      w_err     <= 1'b0;
      axi_bid   <= '0;
      axi_bresp <= OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            w_idx   <= word_idx(axi_awaddr);
            w_cnt   <= '0;
            w_len   <= axi_awlen;
            w_err   <= out_of_range(axi_awaddr) || (axi_awburst != 2'b01) ||
                       (axi_awsize != SIZE_OK);
            axi_bid <= axi_awid;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_idx <= w_idx + IDX_W'(1);
            w_cnt <= w_cnt + 8'd1;
            if (w_wlast_bad) w_err <= 1'b1;
            if (w_last_beat) begin
              axi_bresp <= (w_err || w_wlast_bad) ? SLVERR : OKAY;
              w_state   <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi_bready) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_hs && !w_err) mem[w_idx] <= axi_wdata;
  end

endmodule
